// File: rtl/quad_input_filter.sv
// rtl/quad_input_filter.sv - synchronise and pulse-width filter quadrature A/B/Z inputs.
// Optional: define QUAD_INPUT_FILTER_Z_GATE_EN to assert z only when filtered a and b are both 1.
module quad_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_in,
  input  logic b_in,
  input  logic z_in,
  output logic a,
  output logic b,
  output logic z,
  output logic glitch,
  output logic skip_err
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  // Channel index: 0 = A, 1 = B, 2 = Z
  logic [2:0]                  raw;
  logic [2:0][SYNC_STAGES-1:0] sync_q;
  logic [2:0][CW-1:0]          cnt;
  logic [2:0]                  filt;
  logic [2:0]                  s;
  logic [2:0]                  fire;
  logic [2:0]                  abandon;

  assign raw = {z_in, b_in, a_in};

  always_comb begin
    s       = '0;
    fire    = '0;
    abandon = '0;
    for (int i = 0; i < 3; i++) begin
      s[i]       = sync_q[i][SYNC_STAGES-1];
      fire[i]    = (s[i] != filt[i]) && (cnt[i] == LAST);
      abandon[i] = (s[i] == filt[i]) && (cnt[i] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt      <= '0;
      filt     <= '0;
      glitch   <= 1'b0;
      skip_err <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw[i]};
        if (s[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (fire[i]) begin
          filt[i] <= s[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
      glitch   <= |abandon;
      // a and b committing a new level on the same edge means a lost quadrature step
      skip_err <= fire[0] & fire[1];
    end
  end

  assign a = filt[0];
  assign b = filt[1];
`ifdef QUAD_INPUT_FILTER_Z_GATE_EN
  assign z = filt[2] & filt[0] & filt[1];
`else
  assign z = filt[2];
`endif

endmodule

// File: tb/tb_quad_input_filter.sv
// tb/tb_quad_input_filter.sv - scoreboard bench for quad_input_filter with a windowed reference model.
module tb_quad_input_filter;

  localparam int SS = 2;
  localparam int FL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_in = 1'b0, b_in = 1'b0, z_in = 1'b0;
  logic a, b, z, glitch, skip_err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0] exp_q[$];
  bit         hist[3][$];
  bit         mout[3];
  int         lastchg[3];
  int         k;

  quad_input_filter #(.SYNC_STAGES(SS), .FILTER_LEN(FL)) dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .z_in(z_in),
    .a(a), .b(b), .z(z), .glitch(glitch), .skip_err(skip_err)
  );

  always #5 clk = ~clk;

  // Synchronised level seen by the filter after edge i: the raw sample SS-1 edges earlier
  function automatic bit s_at(int ch, int i);
    int j = i - SS + 1;
    if (j < 0) return 1'b0;
    return hist[ch][j];
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < 3; ch++) begin
      hist[ch].delete();
      mout[ch]    = 1'b0;
      lastchg[ch] = -1;
    end
    k = 0;
  endtask

  // Output flips once the last FL synchronised samples since the previous flip all differ from it
  task automatic model_edge(input bit [2:0] x, output logic [4:0] e);
    bit chg[3];
    bit ab;
    bit zz;
    ab = 1'b0;
    for (int ch = 0; ch < 3; ch++) hist[ch].push_back(x[ch]);
    for (int ch = 0; ch < 3; ch++) begin
      chg[ch] = 1'b0;
      if (k - FL >= lastchg[ch]) begin
        chg[ch] = 1'b1;
        for (int i = k - FL; i < k; i++)
          if (s_at(ch, i) == mout[ch]) chg[ch] = 1'b0;
      end
      if (lastchg[ch] != k - 1 && k - 2 >= lastchg[ch] &&
          s_at(ch, k - 2) != mout[ch] && s_at(ch, k - 1) == mout[ch])
        ab = 1'b1;
    end
    for (int ch = 0; ch < 3; ch++)
      if (chg[ch]) begin
        mout[ch]    = ~mout[ch];
        lastchg[ch] = k;
      end
`ifdef QUAD_INPUT_FILTER_Z_GATE_EN
    zz = mout[2] & mout[0] & mout[1];
`else
    zz = mout[2];
`endif
    e = {mout[0], mout[1], zz, ab, chg[0] & chg[1]};
    k++;
  endtask

  task automatic step(input bit xa, input bit xb, input bit xz);
    logic [4:0] e;
    @(negedge clk);
    rst_n = 1'b1;
    a_in  = xa;
    b_in  = xb;
    z_in  = xz;
    model_edge({xz, xb, xa}, e);
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, expv);
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("reset_immediate", {a, b, z, glitch, skip_err}, 0);
    repeat (n) @(posedge clk);
    model_reset();
  endtask

  always @(posedge clk) begin
    logic [4:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({a, b, z, glitch, skip_err} !== e) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t a/b/z/glitch/skip got=%b expected=%b",
                 $time, {a, b, z, glitch, skip_err}, e);
      end
    end
  end

  initial begin
    int rise;
    int hold[3];
    bit cur[3];

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {a, b, z, glitch, skip_err}, 0);
    model_reset();

    repeat (20) step(0, 0, 0);

    // Rise count includes the sampling cycle as cycle 1
    rise = 0;
    step(1, 0, 0);
    for (int m = 2; m < 30; m++) begin
      step(1, 0, 0);
      if (a && rise == 0) rise = m - 1;
    end
    chk("a_latency", rise, SS + FL);
    repeat (10) step(0, 0, 0);

    repeat (3) step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    repeat (4) step(0, 1, 0);
    repeat (12) step(0, 0, 0);

    repeat (10) step(1, 1, 0);
    repeat (10) step(0, 0, 0);
    repeat (2) step(1, 0, 0);
    repeat (10) step(1, 1, 0);
    repeat (10) step(0, 0, 0);

    repeat (4) step(1, 0, 0);
    do_reset(2);
    repeat (12) step(1, 0, 0);
    repeat (10) step(0, 0, 0);

    repeat (10) step(1, 0, 1);
    repeat (10) step(1, 1, 1);
    repeat (10) step(0, 0, 0);

    for (int ch = 0; ch < 3; ch++) begin
      hold[ch] = 0;
      cur[ch]  = 1'b0;
    end
    for (int c = 0; c < 2000; c++) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (hold[ch] == 0) begin
          cur[ch]  = 1'($urandom_range(0, 1));
          hold[ch] = $urandom_range(1, 7);
        end
        hold[ch]--;
      end
      if ($urandom_range(0, 499) == 0) do_reset($urandom_range(1, 3));
      step(cur[0], cur[1], cur[2]);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
